lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store sequencer between the pipeline's memory stage and the byte-wide data memory. It accepts one RV32I load or store per request handshake (LB/LH/LW/LBU/LHU/SB/SH/SW), walks the required bytes over the memory port one byte per cycle, and returns assembled, sign- or zero-extended load data. It also flags misaligned and illegal requests.

## Interface
- ALIGN_CHECK, 1, 1: misaligned halfword/word requests complete with error and no memory access; 0: accessed bytewise anyway.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request; high exactly in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (size in [1:0], unsigned in [2])
- req_addr  in  32  byte address
- req_wdata  in  32  store data, byte 0 = [7:0]
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal request
- mem_en  out  1  memory byte access this cycle
- mem_we  out  1  byte write strobe (only with mem_en)
- mem_addr  out  32  byte address
- mem_wdata  out  8  byte to write
- mem_rdata  in  8  combinational read byte at mem_addr
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch we, funct3, addr, wdata; clear data buffer; cnt=0.
  - nbytes: funct3[1:0]=00→1, 01→2, 10→4.
  - Illegal: funct3[1:0]=11; load funct3=110/111; store funct3[2]=1. Illegal → RESP, err=1.
  - Misaligned (ALIGN_CHECK=1): half with addr[0]=1; word with addr[1:0]!=0 → RESP, err=1, no mem_en.
  - Otherwise → ACCESS.
- ACCESS, one byte per cycle:
  - mem_en=1, mem_we=we, mem_addr=base+cnt (mod 2^32, wraps), mem_wdata=wdata[8*cnt+7:8*cnt].
  - Load: at the clock edge, buffer byte lane cnt gets mem_rdata.
  - cnt increments; after byte nbytes-1, go to RESP.
- RESP: rsp_valid=1, held stable until rsp_ready; on rsp_valid&&rsp_ready → IDLE.
  - Load, no error: rsp_rdata = buffer. funct3[2]=0 sign-extends from bit 8*nbytes-1; funct3[2]=1 zero-extends.
- mem_en=0 and mem_we=0 in IDLE and RESP; mem_addr/mem_wdata are 0 when mem_en=0.
- Never accepts a new request while busy; no request queuing.
- Bytes little-endian: lowest address = least significant byte.

## Timing
- Reset values: state IDLE, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cnt=0, buffer=0.
- Accept edge = cycle 0. ACCESS occupies cycles 1..nbytes. rsp_valid first high in cycle nbytes+1.
- Error response: rsp_valid high in cycle 1.
- With rsp_ready tied high: request-to-request throughput is nbytes+2 cycles (2 for errors).
- rsp_ready low holds RESP, rsp_rdata and rsp_err indefinitely; no memory activity while held.
- Reset mid-ACCESS: immediate return to IDLE, no response produced. Store bytes already written stay written; no further mem_we.
- Reset during RESP drops the response.
- req_valid deasserted while busy has no effect; inputs are sampled only at the accept edge.

## Test plan
- SW 0xDEADBEEF @0x100, then LW @0x100 → store: mem_we in cycles 1–4 at 0x100–0x103 with bytes EF,BE,AD,DE; load: rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid in cycle 5.
- Memory byte 0x80 @0x200: LB → 0xFFFFFF80; LBU → 0x00000080. Bytes 0x34,0x92 @0x202: LH → 0xFFFF9234; LHU → 0x00009234.
- SH @0x103 and LW @0x102 with ALIGN_CHECK=1 → rsp_err=1, rsp_rdata=0, mem_en never high, rsp_valid in cycle 1. Same requests with ALIGN_CHECK=0 → normal bytewise access, err=0.
- funct3=011 load and funct3=100 store → rsp_err=1, no mem_en.
- LW with rsp_ready low for 3 cycles → rsp_valid/rsp_rdata stable, req_ready=0 throughout; IDLE one cycle after rsp_ready=1.
- Reset asserted after 2 byte-writes of SW 0x11223344 @0x300 → only 0x300=0x44 and 0x301=0x33 written, rsp_valid stays 0, req_ready=1 after reset. SW @0xFFFFFFFE with ALIGN_CHECK=0 → writes 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: byte-serial load/store sequencer between the memory stage and a
// byte-wide data memory. One RV32I load/store per request handshake, one byte
// per cycle on the memory port, little-endian assembly with sign/zero extension.
module lsu_ctrl #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] base_q;
    logic [31:0] wdata_q;
    logic [31:0] buf_q;
    logic [1:0]  cnt_q;

    logic        req_illegal;
    logic        req_misaligned;
    logic [1:0]  last_cnt;
    logic [1:0]  cnt_nxt;
    logic [31:0] buf_nxt;

    // Select byte lane idx of a 32-bit word (lane 0 = bits [7:0]).
    function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        b = w[7:0];
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    // Sign- or zero-extend the assembled load buffer according to funct3.
    function automatic logic [31:0] extend(input logic [31:0] b, input logic [2:0] f3);
        logic [31:0] r;
        r = b;
        case (f3[1:0])
            2'b00:   r = f3[2] ? {24'b0, b[7:0]}  : {{24{b[7]}}, b[7:0]};
            2'b01:   r = f3[2] ? {16'b0, b[15:0]} : {{16{b[15]}}, b[15:0]};
            default: r = b;
        endcase
        return r;
    endfunction

    // Request decode: illegal encodings and (optionally) natural-alignment violations.
    always_comb begin
        req_illegal = (req_funct3[1:0] == 2'b11)
                   || (!req_we && (req_funct3[2:1] == 2'b11))
                   || (req_we && req_funct3[2]);
        req_misaligned = ALIGN_CHECK
                      && (((req_funct3[1:0] == 2'b01) && req_addr[0])
                       || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
    end

    // Byte index of the final access and the buffer with the current read byte merged in.
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   last_cnt = 2'd0;
            2'b01:   last_cnt = 2'd1;
            default: last_cnt = 2'd3;
        endcase
        cnt_nxt = cnt_q + 2'd1;
        buf_nxt = buf_q;
        case (cnt_q)
            2'd0:    buf_nxt[7:0]   = mem_rdata;
            2'd1:    buf_nxt[15:8]  = mem_rdata;
            2'd2:    buf_nxt[23:16] = mem_rdata;
            default: buf_nxt[31:24] = mem_rdata;
        endcase
    end

    // Sequencer: state, request latches and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            we_q      <= 1'b0;
            funct3_q  <= 3'b0;
            base_q    <= 32'b0;
            wdata_q   <= 32'b0;
            buf_q     <= 32'b0;
            cnt_q     <= 2'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'b0;
            rsp_err   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'b0;
            mem_wdata <= 8'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        funct3_q  <= req_funct3;
                        base_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        buf_q     <= 32'b0;
                        cnt_q     <= 2'b0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_illegal || req_misaligned) begin
                            // Error responses skip the memory entirely.
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'b0;
                        end else begin
                            state     <= StAccess;
                            mem_en    <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= req_addr;
                            mem_wdata <= req_wdata[7:0];
                        end
                    end
                end
                StAccess: begin
                    if (!we_q) begin
                        buf_q <= buf_nxt;
                    end
                    cnt_q <= cnt_nxt;
                    if (cnt_q == last_cnt) begin
                        state     <= StResp;
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'b0;
                        mem_wdata <= 8'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= we_q ? 32'b0 : extend(buf_nxt, funct3_q);
                    end else begin
                        // Address wraps modulo 2^32 naturally.
                        mem_addr  <= base_q + {30'b0, cnt_nxt};
                        mem_wdata <= byte_lane(wdata_q, cnt_nxt);
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state     <= StIdle;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= StIdle;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and randomized checks of lsu_ctrl against a byte-array
// reference model. Instance 0 has alignment checking off, instance 1 on.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        init_mem;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_err    [2];
    logic        mem_en     [2];
    logic        mem_we     [2];
    logic [31:0] mem_addr   [2];
    logic [7:0]  mem_wdata  [2];
    logic [7:0]  mem_rdata  [2];
    logic        busy       [2];

    logic [7:0]  dut_mem [0:1023];
    logic [7:0]  ref_mem [0:1023];

    int n_assert = 0;
    int n_fail   = 0;

    lsu_ctrl #(.ALIGN_CHECK(1'b0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .busy(busy[0])
    );

    lsu_ctrl #(.ALIGN_CHECK(1'b1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1 KiB byte memory (address bits [9:0]) shared by both instances.
    assign mem_rdata[0] = dut_mem[mem_addr[0][9:0]];
    assign mem_rdata[1] = dut_mem[mem_addr[1][9:0]];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) dut_mem[i] <= 8'(i * 37 + 5);
        end else begin
            for (int d = 0; d < 2; d++)
                if (mem_en[d] && mem_we[d]) dut_mem[mem_addr[d][9:0]] <= mem_wdata[d];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: decides error, byte count and load result; applies stores to ref_mem.
    task automatic model(input int d, input bit we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output bit err, output int nb, output logic [31:0] rdata);
        int size;
        bit illegal;
        bit mis;
        longint unsigned v;
        logic [31:0] a;
        size    = int'(f3[1:0]);
        illegal = (size == 3) || (!we && f3 >= 3'd6) || (we && f3 >= 3'd4);
        mis     = (d == 1) && ((size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0));
        err     = illegal || mis;
        nb      = (size == 3) ? 0 : (1 << size);
        rdata   = 32'h0;
        v       = 0;
        if (!err) begin
            for (int i = 0; i < nb; i++) begin
                a = addr + 32'(i);
                if (we) ref_mem[a[9:0]] = 8'(wdata >> (8 * i));
                else    v = v | (longint'(ref_mem[a[9:0]]) << (8 * i));
            end
            if (!we) begin
                if (f3 < 3'd4 && ((v >> (8 * nb - 1)) & 1) == 1)
                    v = v | (64'hFFFF_FFFF ^ ((64'd1 << (8 * nb)) - 1));
                rdata = v[31:0];
            end
        end
    endtask

    // One full transaction on instance d; starts and ends at a negedge with the DUT idle.
    task automatic run_req(input int d, input bit we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                           output logic [31:0] o_rdata, output logic o_err);
        bit          e_err;
        int          e_nb;
        logic [31:0] e_rdata;
        int          cyc;
        int          nacc;
        logic [31:0] held;
        model(d, we, f3, addr, wdata, e_err, e_nb, e_rdata);
        chk("idle_req_ready", 32'(req_ready[d]), 32'd1);
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_funct3[d] = f3;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        rsp_ready[d]  = (hold == 0);
        @(negedge clk);
        // Scramble request inputs: only the accept edge may matter.
        req_valid[d]  = 1'b0;
        req_we[d]     = 1'($urandom);
        req_funct3[d] = 3'($urandom);
        req_addr[d]   = $urandom;
        req_wdata[d]  = $urandom;
        cyc  = 1;
        nacc = 0;
        while (rsp_valid[d] !== 1'b1 && cyc < 12) begin
            chk("access_req_ready", 32'(req_ready[d]), 32'd0);
            if (mem_en[d] === 1'b1) begin
                chk("mem_addr", mem_addr[d], addr + 32'(nacc));
                chk("mem_we", 32'(mem_we[d]), 32'(we));
                if (we) chk("mem_wdata", 32'(mem_wdata[d]), (wdata >> (8 * nacc)) & 32'hFF);
                nacc++;
            end else begin
                chk("mem_off", mem_addr[d] | 32'(mem_wdata[d]) | 32'(mem_we[d]), 32'd0);
            end
            @(negedge clk);
            cyc++;
        end
        chk("rsp_valid", 32'(rsp_valid[d]), 32'd1);
        chk("rsp_cycle", 32'(cyc), e_err ? 32'd1 : 32'(e_nb + 1));
        chk("mem_accesses", 32'(nacc), e_err ? 32'd0 : 32'(e_nb));
        chk("rsp_err", 32'(rsp_err[d]), 32'(e_err));
        chk("rsp_rdata", rsp_rdata[d], e_rdata);
        chk("resp_req_ready", 32'(req_ready[d]), 32'd0);
        chk("resp_mem_en", 32'(mem_en[d]), 32'd0);
        o_rdata = rsp_rdata[d];
        o_err   = rsp_err[d];
        held    = rsp_rdata[d];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
            chk("hold_rdata", rsp_rdata[d], held);
            chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
            chk("hold_mem_en", 32'(mem_en[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        chk("done_req_ready", 32'(req_ready[d]), 32'd1);
        chk("done_rsp_valid", 32'(rsp_valid[d]), 32'd0);
        chk("done_busy", 32'(busy[d]), 32'd0);
    endtask

    task automatic chk_reset_state(input int d);
        chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
        chk("rst_busy", 32'(busy[d]), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
        chk("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
        chk("rst_mem_en", 32'(mem_en[d]), 32'd0);
        chk("rst_mem_we", 32'(mem_we[d]), 32'd0);
        chk("rst_mem_addr", mem_addr[d], 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata[d]), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] ad;
        logic [2:0]  f3;
        bit          we;

        rst      = 1'b1;
        init_mem = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = 3'b0;
            req_addr[d] = 32'b0; req_wdata[d] = 32'b0; rsp_ready[d] = 1'b1;
        end
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 37 + 5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        init_mem = 1'b0;
        chk_reset_state(0);
        chk_reset_state(1);
        rst = 1'b0;
        @(negedge clk);

        // SW then LW round trip.
        run_req(1, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, rd, er);
        chk("sw_byte0", 32'(dut_mem[10'h100]), 32'hEF);
        chk("sw_byte1", 32'(dut_mem[10'h101]), 32'hBE);
        chk("sw_byte2", 32'(dut_mem[10'h102]), 32'hAD);
        chk("sw_byte3", 32'(dut_mem[10'h103]), 32'hDE);
        run_req(1, 1'b0, 3'b010, 32'h100, 32'h0, 0, rd, er);
        chk("lw_const", rd, 32'hDEADBEEF);

        // Sign/zero extension of bytes and halfwords.
        run_req(1, 1'b1, 3'b000, 32'h200, 32'h80, 0, rd, er);
        run_req(1, 1'b1, 3'b000, 32'h202, 32'h34, 0, rd, er);
        run_req(1, 1'b1, 3'b000, 32'h203, 32'h92, 0, rd, er);
        run_req(1, 1'b0, 3'b000, 32'h200, 32'h0, 0, rd, er);
        chk("lb_const", rd, 32'hFFFFFF80);
        run_req(1, 1'b0, 3'b100, 32'h200, 32'h0, 0, rd, er);
        chk("lbu_const", rd, 32'h00000080);
        run_req(1, 1'b0, 3'b001, 32'h202, 32'h0, 0, rd, er);
        chk("lh_const", rd, 32'hFFFF9234);
        run_req(1, 1'b0, 3'b101, 32'h202, 32'h0, 0, rd, er);
        chk("lhu_const", rd, 32'h00009234);

        // Misaligned and illegal requests with alignment checking.
        run_req(1, 1'b1, 3'b001, 32'h103, 32'h5566, 0, rd, er);
        chk("sh_mis_err", 32'(er), 32'd1);
        run_req(1, 1'b0, 3'b010, 32'h102, 32'h0, 0, rd, er);
        chk("lw_mis_err", 32'(er), 32'd1);
        chk("lw_mis_rdata", rd, 32'd0);
        run_req(1, 1'b0, 3'b011, 32'h100, 32'h0, 0, rd, er);
        chk("ld011_err", 32'(er), 32'd1);
        run_req(1, 1'b1, 3'b100, 32'h100, 32'h0, 0, rd, er);
        chk("st100_err", 32'(er), 32'd1);

        // Response backpressure.
        run_req(1, 1'b0, 3'b010, 32'h100, 32'h0, 3, rd, er);
        chk("lw_hold_const", rd, 32'hDEADBEEF);

        // Same misaligned requests without alignment checking.
        run_req(0, 1'b1, 3'b001, 32'h103, 32'h5566, 0, rd, er);
        chk("sh_noalign_err", 32'(er), 32'd0);
        chk("sh_noalign_b0", 32'(dut_mem[10'h103]), 32'h66);
        chk("sh_noalign_b1", 32'(dut_mem[10'h104]), 32'h55);
        run_req(0, 1'b0, 3'b010, 32'h102, 32'h0, 0, rd, er);
        chk("lw_noalign_err", 32'(er), 32'd0);

        // Address wrap at the top of the address space.
        run_req(0, 1'b1, 3'b010, 32'hFFFFFFFE, 32'hA1B2C3D4, 0, rd, er);
        chk("wrap_b0", 32'(dut_mem[10'h3FE]), 32'hD4);
        chk("wrap_b1", 32'(dut_mem[10'h3FF]), 32'hC3);
        chk("wrap_b2", 32'(dut_mem[10'h000]), 32'hB2);
        chk("wrap_b3", 32'(dut_mem[10'h001]), 32'hA1);

        // Reset after two store bytes have been written.
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = 3'b010;
        req_addr[1] = 32'h300; req_wdata[1] = 32'h11223344; rsp_ready[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_mem_we", 32'(mem_we[1]), 32'd0);
        chk("mid_rst_mem_en", 32'(mem_en[1]), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready[1]), 32'd1);
        chk("mid_rst_busy", 32'(busy[1]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_b0", 32'(dut_mem[10'h300]), 32'h44);
        chk("mid_rst_b1", 32'(dut_mem[10'h301]), 32'h33);
        chk("mid_rst_b2", 32'(dut_mem[10'h302]), 32'(ref_mem[10'h302]));
        chk("mid_rst_b3", 32'(dut_mem[10'h303]), 32'(ref_mem[10'h303]));
        ref_mem[10'h300] = 8'h44;
        ref_mem[10'h301] = 8'h33;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        end
        chk("post_rst_req_ready", 32'(req_ready[1]), 32'd1);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 80; t++) begin
            we = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            ad = $urandom;
            if ($urandom_range(0, 2) != 0) ad[1:0] = 2'b00;
            run_req(int'($urandom_range(0, 1)), we, f3, ad, $urandom,
                    int'($urandom_range(0, 2)), rd, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
